// File: rtl/dis_pkg.sv
// Shared opcode constants and register-usage decode helpers for the dual-issue scheduler.
package dis_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0,x0,0
  localparam logic [31:0] DIS_NOP = 32'h0000_0013;

  function automatic logic writes_rd(input logic [6:0] op);
    writes_rd = (op == OP_R)    || (op == OP_I)     || (op == OP_LOAD) ||
                (op == OP_LUI)  || (op == OP_AUIPC) || (op == OP_JAL)  ||
                (op == OP_JALR);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    reads_rs1 = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    reads_rs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    is_ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_pair_check.sv
// pair_check: decides whether two adjacent program-order instructions may issue together.
module pair_check
  import dis_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        pair_ok
);

  logic [6:0] w_op_a;
  logic [6:0] w_op_b;
  logic [4:0] w_rd_a;
  logic [4:0] w_rd_b;
  logic [4:0] w_rs1_b;
  logic [4:0] w_rs2_b;
  logic       w_a_writes;
  logic       w_raw;
  logic       w_waw;
  logic       w_mem;
  logic       w_ctrl;
  logic       w_unused;

  assign w_op_a  = a[6:0];
  assign w_op_b  = b[6:0];
  assign w_rd_a  = a[11:7];
  assign w_rd_b  = b[11:7];
  assign w_rs1_b = b[19:15];
  assign w_rs2_b = b[24:20];

  // x0 is never a real destination, so writes to it create no hazard
  assign w_a_writes = writes_rd(w_op_a) && (w_rd_a != 5'd0);

  assign w_raw  = w_a_writes &&
                  ((reads_rs1(w_op_b) && (w_rs1_b == w_rd_a)) ||
                   (reads_rs2(w_op_b) && (w_rs2_b == w_rd_a)));
  assign w_waw  = w_a_writes && writes_rd(w_op_b) && (w_rd_b == w_rd_a);
  assign w_mem  = is_mem(w_op_a) && is_mem(w_op_b);
  assign w_ctrl = is_ctrl(w_op_a);

  assign pair_ok = !(w_raw || w_waw || w_mem || w_ctrl);

  assign w_unused = ^{a[31:12], b[31:25], b[14:12]};

endmodule

// File: rtl/dual_issue_scheduler.sv
// Circular instruction-pair queue feeding two in-order issue slots.
// Optional DIS_PERF_CNT_EN adds perf_dual / perf_single issue counters.
module dual_issue_scheduler
  import dis_pkg::*;
#(
  parameter int          QDEPTH = 4,
  parameter logic [31:0] NOP    = DIS_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr1,
  input  logic [31:0] fetch_instr2,
  output logic        fetch_ready,
  input  logic        issue_ready,
  output logic [31:0] issue_instr1,
  output logic [31:0] issue_instr2,
  output logic        issue_valid1,
  output logic        issue_valid2,
  input  logic        flush
`ifdef DIS_PERF_CNT_EN
  ,
  output logic [31:0] perf_dual,
  output logic [31:0] perf_single
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [QDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_wr_ptr_p1;
  logic [PW-1:0] w_rd_ptr_p1;
  logic [31:0]   w_head_a;
  logic [31:0]   w_head_b;
  logic          w_pair_ok;
  logic          w_valid1;
  logic          w_valid2;
  logic          w_push;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_n;

  assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr_p1 = r_rd_ptr + PW'(1);
  assign w_head_a    = r_mem[r_rd_ptr];
  assign w_head_b    = r_mem[w_rd_ptr_p1];

  pair_check u_pair_check (
    .a       (w_head_a),
    .b       (w_head_b),
    .pair_ok (w_pair_ok)
  );

  // Space is judged on the current count only; a same-cycle pop does not help
  assign fetch_ready = (CW'(QDEPTH) - r_count) >= CW'(2);
  assign w_push      = fetch_valid && fetch_ready;
  assign w_push_n    = w_push ? CW'(2) : '0;

  assign w_valid1 = (r_count != '0);
  assign w_valid2 = (r_count >= CW'(2)) && w_pair_ok;
  assign w_pop_n  = issue_ready ? (CW'(w_valid1) + CW'(w_valid2)) : '0;

  assign issue_valid1 = w_valid1;
  assign issue_valid2 = w_valid2;
  assign issue_instr1 = w_valid1 ? w_head_a : NOP;
  assign issue_instr2 = w_valid2 ? w_head_b : NOP;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr]    <= fetch_instr1;
      r_mem[w_wr_ptr_p1] <= fetch_instr2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(2);
      end
      r_rd_ptr <= r_rd_ptr + w_pop_n[PW-1:0];
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

`ifdef DIS_PERF_CNT_EN
  logic [31:0] r_perf_dual;
  logic [31:0] r_perf_single;

  // A flushed cycle's pop is discarded, so it is not counted as an issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_dual   <= '0;
      r_perf_single <= '0;
    end else if (issue_ready && !flush) begin
      if (w_valid2) begin
        r_perf_dual <= r_perf_dual + 32'd1;
      end else if (w_valid1) begin
        r_perf_single <= r_perf_single + 32'd1;
      end
    end
  end

  assign perf_dual   = r_perf_dual;
  assign perf_single = r_perf_single;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_dual_issue_scheduler;

  localparam int QDEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] I_ADD1 = 32'h003100B3;
  localparam logic [31:0] I_ADD6 = 32'h00838333;
  localparam logic [31:0] I_RAW  = 32'h00508233;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00312223;
  localparam logic [31:0] I_BEQ  = 32'h00208063;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_instr1 = '0;
  logic [31:0] fetch_instr2 = '0;
  logic        fetch_ready;
  logic        issue_ready = 1'b0;
  logic [31:0] issue_instr1;
  logic [31:0] issue_instr2;
  logic        issue_valid1;
  logic        issue_valid2;
  logic        flush = 1'b0;
`ifdef DIS_PERF_CNT_EN
  logic [31:0] perf_dual;
  logic [31:0] perf_single;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mq[$];
  int m_dual = 0;
  int m_single = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.QDEPTH(QDEPTH), .NOP(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_instr1 (fetch_instr1),
    .fetch_instr2 (fetch_instr2),
    .fetch_ready  (fetch_ready),
    .issue_ready  (issue_ready),
    .issue_instr1 (issue_instr1),
    .issue_instr2 (issue_instr2),
    .issue_valid1 (issue_valid1),
    .issue_valid2 (issue_valid2),
    .flush        (flush)
`ifdef DIS_PERF_CNT_EN
    ,
    .perf_dual    (perf_dual),
    .perf_single  (perf_single)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Register that an instruction writes, or -1 when it writes nothing real
  function automatic int dest_of(input logic [31:0] x);
    logic [6:0] op = x[6:0];
    if ((op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                    7'b0010111, 7'b1101111, 7'b1100111}) && (x[11:7] != 5'd0))
      return int'(x[11:7]);
    return -1;
  endfunction

  function automatic bit uses_reg(input logic [31:0] x, input int r);
    logic [6:0] op = x[6:0];
    if (!(op inside {7'b0110111, 7'b0010111, 7'b1101111}) && int'(x[19:15]) == r) return 1'b1;
    if ((op inside {7'b0110011, 7'b0100011, 7'b1100011}) && int'(x[24:20]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit can_pair(input logic [31:0] a, input logic [31:0] b);
    int wa = dest_of(a);
    if (a[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111}) return 1'b0;
    if ((a[6:0] inside {7'b0000011, 7'b0100011}) && (b[6:0] inside {7'b0000011, 7'b0100011})) return 1'b0;
    if (wa >= 0 && (uses_reg(b, wa) || dest_of(b) == wa)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    bit e_v1 = mq.size() >= 1;
    bit e_v2 = (mq.size() >= 2) && can_pair(mq[0], mq[1]);
    chk("valid1", 32'(issue_valid1), 32'(e_v1));
    chk("valid2", 32'(issue_valid2), 32'(e_v2));
    chk("instr1", issue_instr1, e_v1 ? mq[0] : NOP);
    chk("instr2", issue_instr2, e_v2 ? mq[1] : NOP);
    chk("fetch_ready", 32'(fetch_ready), 32'((QDEPTH - mq.size()) >= 2));
`ifdef DIS_PERF_CNT_EN
    chk("perf_dual", perf_dual, 32'(m_dual));
    chk("perf_single", perf_single, 32'(m_single));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input bit fv, input logic [31:0] i1, input logic [31:0] i2,
                      input bit ir, input bit fl, output bit accepted);
    int n = mq.size();
    int popn = 0;
    fetch_valid = fv; fetch_instr1 = i1; fetch_instr2 = i2;
    issue_ready = ir; flush = fl;
    if (ir && n >= 1) popn = (n >= 2 && can_pair(mq[0], mq[1])) ? 2 : 1;
    accepted = fv && ((QDEPTH - n) >= 2) && !fl;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (popn) void'(mq.pop_front());
      if (accepted) begin
        mq.push_back(i1);
        mq.push_back(i2);
      end
      if (popn == 2) m_dual++;
      else if (popn == 1) m_single++;
    end
    @(negedge clk);
    cyc++;
    $display("cyc=%0d fv=%0d ir=%0d fl=%0d push=%0d pop=%0d size=%0d",
             cyc, fv, ir, fl, accepted, fl ? 0 : popn, mq.size());
    check_outputs();
  endtask

  task automatic idle(input bit ir);
    bit acc;
    step(1'b0, '0, '0, ir, 1'b0, acc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    logic [31:0] r = $urandom;
    return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    bit acc;
    bit have;
    logic [31:0] h1, h2;

    repeat (2) @(negedge clk);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_valid1", 32'(issue_valid1), 32'd0);
    chk("rst_instr1", issue_instr1, NOP);
    reset = 1'b0;
    @(negedge clk);
    check_outputs();

    // Independent pair issues together
    step(1'b1, I_ADD1, I_ADD6, 1'b1, 1'b0, acc);
    chk("indep_v2", 32'(issue_valid2), 32'd1);
    chk("indep_i2", issue_instr2, I_ADD6);
    idle(1'b1);
    chk("indep_empty", 32'(issue_valid1), 32'd0);

    // RAW dependency splits the pair
    step(1'b1, I_ADD1, I_RAW, 1'b1, 1'b0, acc);
    chk("raw_i1", issue_instr1, I_ADD1);
    chk("raw_i2", issue_instr2, NOP);
    idle(1'b1);
    chk("raw_second", issue_instr1, I_RAW);
    idle(1'b1);

    // Two memory ops, then branch in slot A
    step(1'b1, I_LW, I_SW, 1'b1, 1'b0, acc);
    chk("mem_v2", 32'(issue_valid2), 32'd0);
    idle(1'b1);
    chk("mem_second", issue_instr1, I_SW);
    idle(1'b1);
    step(1'b1, I_BEQ, I_ADD6, 1'b1, 1'b0, acc);
    chk("br_i2", issue_instr2, NOP);
    idle(1'b1);
    idle(1'b1);

    // Fill the queue under backpressure; third pair must be held
    step(1'b1, I_ADD1, I_ADD6, 1'b0, 1'b0, acc);
    step(1'b1, I_LW, I_SW, 1'b0, 1'b0, acc);
    chk("full_ready", 32'(fetch_ready), 32'd0);
    step(1'b1, I_ADD1, I_RAW, 1'b0, 1'b0, acc);
    chk("full_held", 32'(acc), 32'd0);
    chk("full_hold_head", issue_instr1, I_ADD1);
    have = 1'b1;
    for (int k = 0; k < 12 && have; k++) begin
      step(1'b1, I_ADD1, I_RAW, 1'b1, 1'b0, acc);
      if (acc) have = 1'b0;
    end
    chk("held_pair_taken", 32'(have), 32'd0);
    repeat (6) idle(1'b1);

    // Flush with three entries queued and a simultaneous push
    step(1'b1, I_ADD1, I_RAW, 1'b0, 1'b0, acc);
    step(1'b1, I_ADD6, I_LW, 1'b1, 1'b0, acc);
    chk("pre_flush_head", issue_instr1, I_RAW);
    step(1'b1, I_SW, I_BEQ, 1'b1, 1'b1, acc);
    chk("flush_v1", 32'(issue_valid1), 32'd0);
    chk("flush_ready", 32'(fetch_ready), 32'd1);

    // Asynchronous reset between edges
    step(1'b1, I_ADD1, I_ADD6, 1'b0, 1'b0, acc);
    fetch_valid = 1'b0; issue_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_v1", 32'(issue_valid1), 32'd0);
    chk("areset_i1", issue_instr1, NOP);
    chk("areset_ready", 32'(fetch_ready), 32'd1);
    mq.delete();
    m_dual = 0;
    m_single = 0;
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // Randomized traffic; fetch holds each pair until accepted
    have = 1'b0;
    for (int k = 0; k < 600; k++) begin
      bit fl, ir;
      if (!have && $urandom_range(0, 3) != 0) begin
        h1 = rand_instr();
        h2 = rand_instr();
        have = 1'b1;
      end
      ir = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 31) == 0;
      step(have, h1, h2, ir, fl, acc);
      if (acc || fl) have = 1'b0;
    end
    repeat (4) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
